alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequencing FSM for the multi-cycle ALU datapath: accepts an operation via a start/ready handshake, issues per-cycle control strobes for add/sub, radix-2 Booth multiply and non-restoring divide, and counts iterations internally. It sits between the ALU top-level command interface and the operand/accumulator/quotient registers. It does no arithmetic itself.

Parameters:
WIDTH, 8, operand width in bits; also the number of multiply/divide iterations
CNT_W, 3, iteration counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  operation request; accepted only when ready=1
op_sel  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; sampled with start
ready  output  1  high only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result registers valid
err  output  1  divide-by-zero flag; valid with done, held until next acceptance
q0_qm1  input  2  Booth examine bits {Q[0], Q[-1]} from datapath
acc_sign  input  1  accumulator MSB from datapath
divisor_zero  input  1  divisor==0, valid in LOAD
ld_operands  output  1  load operand registers, clear accumulator/Q[-1]
alu_addsub  output  1  single add/sub execute strobe
alu_sub  output  1  1=subtract for add/sub, Booth and divide steps
booth_add  output  1  Booth step adds/subtracts M (direction via alu_sub)
ar_shift  output  1  arithmetic right shift of {A,Q,Q[-1]}
div_step  output  1  non-restoring step: shift left {A,Q}, add/sub M, set Q[0]=~new sign
div_correct  output  1  remainder correction A<=A+M
iter  output  CNT_W  current iteration index (debug/observability)

Behaviour:
- States: IDLE, LOAD, ADDSUB, MUL_STEP, DIV_STEP, DIV_CORR, DONE. Binary encoded.
- Reset (asynchronous): state=IDLE, op_q=00, iter=0, err=0. All strobes 0, ready=1, busy=0, done=0. Reset mid-operation abandons the operation; no done is issued.
- IDLE: if start, latch op_q<=op_sel, clear err and iter, go to LOAD. Otherwise stay.
- start while busy is ignored and not queued.
- LOAD: assert ld_operands. Next state is ADDSUB if op_q is ADD/SUB, MUL_STEP if MUL.
- LOAD with DIV: if divisor_zero=1, set err=1 and go to DONE; otherwise go to DIV_STEP.
- ADDSUB: assert alu_addsub, with alu_sub=op_q[0]; go to DONE.
- MUL_STEP: ar_shift=1 every cycle.
  - q0_qm1=10: booth_add=1, alu_sub=1.
  - q0_qm1=01: booth_add=1, alu_sub=0.
  - q0_qm1=00 or 11: booth_add=0.
  - iter increments. When iter==WIDTH-1, clear iter and go to DONE.
- DIV_STEP: div_step=1, alu_sub=~acc_sign (acc_sign sampled before the step). iter increments; at iter==WIDTH-1, clear iter and go to DIV_CORR.
- DIV_CORR: div_correct=acc_sign, so the correction is applied only when the remainder is negative. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE. A start in the DONE cycle is ignored.
- All strobes are combinational decodes of state (plus q0_qm1/acc_sign where stated) and are 0 in IDLE and DONE.
- Latency, with start accepted at the edge ending cycle T, done is high in cycle:
  - ADD/SUB: T+3
  - MUL: T+WIDTH+2
  - DIV: T+WIDTH+3
  - DIV by zero: T+2
- Back-to-back: the earliest next acceptance is in the cycle after DONE, giving one idle cycle minimum.
- iter wraps only via explicit clear. It never exceeds WIDTH-1.

Decomposition:
- Package alu_pkg holds:
  - op_t enum (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11)
  - state_t enum
  - Booth code constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10
- One sub-module, iter_counter (CNT_W-bit, synchronous clear, increment enable, terminal-count output at WIDTH-1), instantiated once for iter.

Test Plan:
- ADD, WIDTH=8: start with op_sel=00 at T → ld_operands at T+1, alu_addsub=1/alu_sub=0 at T+2, done at T+3, err=0, ready back at T+4.
- MUL, 8 steps, q0_qm1 driven 10,11,01,00,...: booth_add/alu_sub follow 1/1, 0/x, 1/0, 0/x. ar_shift high exactly 8 cycles; iter runs 0..7; done at T+10.
- DIV with acc_sign=1 after the last step: div_step high exactly 8 cycles, div_correct=1 in DIV_CORR, done at T+11. Repeat with acc_sign=0 → div_correct=0.
- DIV by zero: divisor_zero=1 in LOAD → no div_step, done with err=1 at T+2. err stays 1 until the next start is accepted.
- start pulsed every cycle during a MUL → ignored while busy; the next op is accepted only in the cycle after done.
- reset asserted at MUL step 4 → immediately state IDLE, ready=1, all strobes 0, iter=0, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU sequencer.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ADDSUB   = 3'd2,
        S_MUL_STEP = 3'd3,
        S_DIV_STEP = 3'd4,
        S_DIV_CORR = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/alu_seq_ctrl_iter_counter.sv
// Iteration counter for multiply/divide loops.
// Clear wins over increment; tc flags the last iteration.
module iter_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the multi-cycle ALU: handshake, per-cycle
// datapath strobes for add/sub, Booth multiply, non-restoring divide.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_sel,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [1:0]       q0_qm1,
    input  logic             acc_sign,
    input  logic             divisor_zero,
    output logic             ld_operands,
    output logic             alu_addsub,
    output logic             alu_sub,
    output logic             booth_add,
    output logic             ar_shift,
    output logic             div_step,
    output logic             div_correct,
    output logic [CNT_W-1:0] iter
);

    state_t state_q, state_d;
    op_t    op_q, op_d;
    logic   err_q, err_d;
    logic   cnt_clr, cnt_inc, cnt_tc;

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (iter),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        err_d       = err_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        ld_operands = 1'b0;
        alu_addsub  = 1'b0;
        alu_sub     = 1'b0;
        booth_add   = 1'b0;
        ar_shift    = 1'b0;
        div_step    = 1'b0;
        div_correct = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_t'(op_sel);
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_operands = 1'b1;
                unique case (op_q)
                    OP_ADD, OP_SUB: state_d = S_ADDSUB;
                    OP_MUL:         state_d = S_MUL_STEP;
                    OP_DIV: begin
                        if (divisor_zero) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_DIV_STEP;
                        end
                    end
                    default:        state_d = S_IDLE;
                endcase
            end
            S_ADDSUB: begin
                alu_addsub = 1'b1;
                alu_sub    = op_q[0];
                state_d    = S_DONE;
            end
            S_MUL_STEP: begin
                ar_shift = 1'b1;
                cnt_inc  = 1'b1;
                // Only 01/10 pairs touch the accumulator
                if (q0_qm1 == BOOTH_SUB) begin
                    booth_add = 1'b1;
                    alu_sub   = 1'b1;
                end else if (q0_qm1 == BOOTH_ADD) begin
                    booth_add = 1'b1;
                end
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DIV_STEP: begin
                div_step = 1'b1;
                alu_sub  = ~acc_sign;
                cnt_inc  = 1'b1;
                if (cnt_tc) begin
                    cnt_clr = 1'b1;
                    state_d = S_DIV_CORR;
                end
            end
            S_DIV_CORR: begin
                div_correct = acc_sign;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (WIDTH=8).
// Expected done cycle/err queued at acceptance, checked on done.
module tb_alu_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op_sel = 2'b00;
    logic          ready, busy, done, err;
    logic [1:0]    q0_qm1 = 2'b00;
    logic          acc_sign = 1'b0;
    logic          divisor_zero = 1'b0;
    logic          ld_operands, alu_addsub, alu_sub, booth_add;
    logic          ar_shift, div_step, div_correct;
    logic [CW-1:0] iter;

    typedef struct {
        int   cyc;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ar = 0;
    int   n_ds = 0;
    logic dz_plan = 1'b0;

    alu_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_sel       (op_sel),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .q0_qm1       (q0_qm1),
        .acc_sign     (acc_sign),
        .divisor_zero (divisor_zero),
        .ld_operands  (ld_operands),
        .alu_addsub   (alu_addsub),
        .alu_sub      (alu_sub),
        .booth_add    (booth_add),
        .ar_shift     (ar_shift),
        .div_step     (div_step),
        .div_correct  (div_correct),
        .iter         (iter)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // One clock: enqueue on acceptance, then sample #1 after the edge
    task automatic tick();
        int lat;
        if (start && ready && !reset) begin
            case (op_sel)
                2'b10:   lat = W + 2;
                2'b11:   lat = dz_plan ? 2 : W + 3;
                default: lat = 3;
            endcase
            exp_q.push_back('{cyc + lat, (op_sel == 2'b11) && dz_plan});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (ar_shift) n_ar++;
        if (div_step) n_ds++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                exp_t e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_err", err, e.err);
            end
        end
    endtask

    task automatic run_addsub(input logic sub);
        start  = 1'b1;
        op_sel = {1'b0, sub};
        tick();
        start = 1'b0;
        check("as_ld", ld_operands, 1);
        check("as_busy", busy, 1);
        check("as_ready", ready, 0);
        tick();
        check("as_strobe", alu_addsub, 1);
        check("as_sub", alu_sub, sub);
        tick();
        check("as_done", done, 1);
        check("as_err", err, 0);
        tick();
        check("as_ready_back", ready, 1);
    endtask

    task automatic run_div(input logic last_sign);
        dz_plan      = 1'b0;
        divisor_zero = 1'b0;
        start        = 1'b1;
        op_sel       = 2'b11;
        n_ds         = 0;
        tick();
        start = 1'b0;
        check("dv_ld", ld_operands, 1);
        for (int i = 0; i < W; i++) begin
            tick();
            acc_sign = (i % 2 == 1);
            #1;
            check("dv_step", div_step, 1);
            check("dv_sub", alu_sub, !acc_sign);
            check("dv_iter", iter, i);
        end
        tick();
        acc_sign = last_sign;
        #1;
        check("dv_corr", div_correct, last_sign);
        check("dv_corr_nostep", div_step, 0);
        tick();
        check("dv_done", done, 1);
        check("dv_nsteps", n_ds, W);
        tick();
    endtask

    logic [1:0] pat [4];

    initial begin
        pat[0] = 2'b10;
        pat[1] = 2'b11;
        pat[2] = 2'b01;
        pat[3] = 2'b00;

        tick();
        tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_iter", iter, 0);
        check("rst_ld", ld_operands, 0);
        reset = 1'b0;
        tick();

        run_addsub(1'b0);
        run_addsub(1'b1);

        // MUL with start held high throughout: must not be queued
        start  = 1'b1;
        op_sel = 2'b10;
        n_ar   = 0;
        tick();
        op_sel = 2'b00;
        check("mu_ld", ld_operands, 1);
        for (int i = 0; i < W; i++) begin
            tick();
            q0_qm1 = pat[i % 4];
            #1;
            check("mu_iter", iter, i);
            check("mu_shift", ar_shift, 1);
            check("mu_booth", booth_add, (i % 4 == 0) || (i % 4 == 2));
            if (i % 4 == 0) check("mu_sub", alu_sub, 1);
            if (i % 4 == 2) check("mu_sub", alu_sub, 0);
        end
        tick();
        check("mu_done", done, 1);
        check("mu_nshift", n_ar, W);
        check("mu_iter_clr", iter, 0);
        check("mu_done_ready", ready, 0);
        tick();
        check("mu_idle_ready", ready, 1);
        tick();
        start = 1'b0;
        check("spam_accept_ld", ld_operands, 1);
        tick();
        tick();
        tick();

        run_div(1'b1);
        run_div(1'b0);

        // Divide by zero
        dz_plan      = 1'b1;
        divisor_zero = 1'b1;
        start        = 1'b1;
        op_sel       = 2'b11;
        n_ds         = 0;
        tick();
        start = 1'b0;
        check("dz_ld", ld_operands, 1);
        tick();
        check("dz_done", done, 1);
        check("dz_err", err, 1);
        tick();
        check("dz_err_hold", err, 1);
        tick();
        check("dz_err_hold2", err, 1);
        check("dz_nsteps", n_ds, 0);
        dz_plan      = 1'b0;
        divisor_zero = 1'b0;
        start        = 1'b1;
        op_sel       = 2'b00;
        tick();
        start = 1'b0;
        check("dz_err_clr", err, 0);
        tick();
        tick();
        tick();

        // Reset in the middle of a multiply
        start  = 1'b1;
        op_sel = 2'b10;
        tick();
        start  = 1'b0;
        q0_qm1 = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        check("rm_iter_pre", iter, 4);
        reset = 1'b1;
        #1;
        check("rm_ready", ready, 1);
        check("rm_busy", busy, 0);
        check("rm_shift", ar_shift, 0);
        check("rm_booth", booth_add, 0);
        check("rm_iter", iter, 0);
        check("rm_done", done, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();
        check("rm_idle", ready, 1);

        run_addsub(1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
